// File: rtl/ext_interrupt_unit_if.sv
// Register-file and pin bundle between the ATMega32A core glue and the
// external interrupt unit; master drives pins/strobes, slave returns state.
interface ext_interrupt_unit_if;
  logic [2:0] pin_in;
  logic       isc_we;
  logic [3:0] isc_data;
  logic       isc2_we;
  logic       isc2_data;
  logic       gicr_we;
  logic [2:0] gicr_data;
  logic       gifr_we;
  logic [2:0] gifr_data;
  logic [2:0] irq_ack;
  logic [3:0] isc_out;
  logic       isc2_out;
  logic [2:0] gicr_out;
  logic [2:0] gifr_out;
  logic [2:0] irq_req;

  modport master (
    output pin_in, isc_we, isc_data, isc2_we, isc2_data,
    output gicr_we, gicr_data, gifr_we, gifr_data, irq_ack,
    input  isc_out, isc2_out, gicr_out, gifr_out, irq_req
  );

  modport slave (
    input  pin_in, isc_we, isc_data, isc2_we, isc2_data,
    input  gicr_we, gicr_data, gifr_we, gifr_data, irq_ack,
    output isc_out, isc2_out, gicr_out, gifr_out, irq_req
  );
endinterface

// File: rtl/ext_interrupt_unit.sv
// INT0/INT1/INT2 external interrupt sense logic: pin synchronisers, level/edge
// detection, GIFR flags and GICR-masked requests to the CPU vector unit.
module ext_interrupt_unit #(
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 clr,
  ext_interrupt_unit_if.slave bus
);

  typedef enum logic [1:0] {
    SENSE_LOW  = 2'b00,
    SENSE_ANY  = 2'b01,
    SENSE_FALL = 2'b10,
    SENSE_RISE = 2'b11
  } sense_e;

  // INT2 reuses this with mode {1, ISC2}, i.e. falling or rising only.
  function automatic logic sense_event(input logic [1:0] mode, input logic cur, input logic prev);
    logic hit;
    case (sense_e'(mode))
      SENSE_ANY:  hit = cur ^ prev;
      SENSE_FALL: hit = prev & ~cur;
      SENSE_RISE: hit = cur & ~prev;
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

  logic [2:0] sync_r [SYNC_STAGES];
  logic [2:0] prev_r;
  logic [3:0] isc_r;
  logic       isc2_r;
  logic [2:0] gicr_r;
  logic [2:0] gifr_r;

  logic [2:0] s_s;
  logic [3:0] isc_nxt_s;
  logic [2:0] level_s;
  logic [2:0] level_nxt_s;
  logic [2:0] event_s;
  logic [2:0] clear_s;
  logic [2:0] gifr_nxt_s;
  logic [2:0] irq_s;

  // Event detection, flag next-state and request masking.
  always_comb begin
    s_s         = sync_r[SYNC_STAGES-1];
    isc_nxt_s   = bus.isc_we ? bus.isc_data : isc_r;
    level_s     = {1'b0, isc_r[3:2] == 2'b00, isc_r[1:0] == 2'b00};
    level_nxt_s = {1'b0, isc_nxt_s[3:2] == 2'b00, isc_nxt_s[1:0] == 2'b00};
    // A sense-mode write masks that cycle's event so the mode change itself never flags.
    event_s[0]  = sense_event(isc_r[1:0], s_s[0], prev_r[0]) & ~bus.isc_we;
    event_s[1]  = sense_event(isc_r[3:2], s_s[1], prev_r[1]) & ~bus.isc_we;
    event_s[2]  = sense_event({1'b1, isc2_r}, s_s[2], prev_r[2]) & ~bus.isc2_we;
    clear_s     = bus.irq_ack | ({3{bus.gifr_we}} & bus.gifr_data);
    gifr_nxt_s  = gifr_r;
    irq_s       = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (event_s[i]) begin
        gifr_nxt_s[i] = 1'b1;
      end else if (level_nxt_s[i] | clear_s[i]) begin
        gifr_nxt_s[i] = 1'b0;
      end else begin
        gifr_nxt_s[i] = gifr_r[i];
      end
      if (level_s[i]) begin
        irq_s[i] = gicr_r[i] & ~s_s[i];
      end else begin
        irq_s[i] = gicr_r[i] & gifr_r[i];
      end
    end
  end

  // Synchronisers, previous-level history and the MCUCR/MCUCSR/GICR/GIFR registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_r[j] <= 3'b111;
      end
      prev_r <= 3'b111;
      isc_r  <= 4'b0000;
      isc2_r <= 1'b0;
      gicr_r <= 3'b000;
      gifr_r <= 3'b000;
    end else begin
      sync_r[0] <= bus.pin_in;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_r[j] <= sync_r[j-1];
      end
      prev_r <= s_s;
      isc_r  <= isc_nxt_s;
      isc2_r <= bus.isc2_we ? bus.isc2_data : isc2_r;
      gicr_r <= bus.gicr_we ? bus.gicr_data : gicr_r;
      gifr_r <= gifr_nxt_s;
    end
  end

  assign bus.isc_out  = isc_r;
  assign bus.isc2_out = isc2_r;
  assign bus.gicr_out = gicr_r;
  assign bus.gifr_out = gifr_r;
  assign bus.irq_req  = irq_s;

endmodule

// File: tb/tb_ext_interrupt_unit.sv
// Scoreboard bench for ext_interrupt_unit: expected output vectors are queued
// as stimulus is applied and popped against the DUT one cycle later.
module tb_ext_interrupt_unit;
  localparam int N = 2;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  ext_interrupt_unit_if bus_if();

  ext_interrupt_unit #(.SYNC_STAGES(N)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  typedef struct {
    string       tag;
    logic [13:0] outs;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        got;
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [3:0]  m_isc;
  logic        m_isc2;
  logic [2:0]  m_gicr;
  logic [13:0] obs;

  assign obs = {bus_if.isc_out, bus_if.isc2_out, bus_if.gicr_out, bus_if.gifr_out, bus_if.irq_req};

  function automatic logic [13:0] exp_outs(input logic [2:0] gifr, input logic [2:0] irq);
    return {m_isc, m_isc2, m_gicr, gifr, irq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_isc(input logic [3:0] d);
    bus_if.isc_data = d; bus_if.isc_we = 1'b1; m_isc = d;
    tick();
    bus_if.isc_we = 1'b0;
  endtask

  task automatic wr_isc2(input logic d);
    bus_if.isc2_data = d; bus_if.isc2_we = 1'b1; m_isc2 = d;
    tick();
    bus_if.isc2_we = 1'b0;
  endtask

  task automatic wr_gicr(input logic [2:0] d);
    bus_if.gicr_data = d; bus_if.gicr_we = 1'b1; m_gicr = d;
    tick();
    bus_if.gicr_we = 1'b0;
  endtask

  task automatic wr_gifr(input logic [2:0] d);
    bus_if.gifr_data = d; bus_if.gifr_we = 1'b1;
    tick();
    bus_if.gifr_we = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.pin_in = 3'b111;
    bus_if.isc_we = 1'b0;  bus_if.isc_data = 4'b0000;
    bus_if.isc2_we = 1'b0; bus_if.isc2_data = 1'b0;
    bus_if.gicr_we = 1'b0; bus_if.gicr_data = 3'b000;
    bus_if.gifr_we = 1'b0; bus_if.gifr_data = 3'b000;
    bus_if.irq_ack = 3'b000;
    m_isc = 4'b0000; m_isc2 = 1'b0; m_gicr = 3'b000;
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    exp_q.push_back('{"reset", 14'd0});
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
    for (int j = 0; j < 10; j++) begin
      exp_q.push_back('{"reset_idle", 14'd0});
      tick();
      got = exp_q.pop_front(); chk_cnt++;
      if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
      else pass_cnt++;
    end
  endtask

  task automatic test_int0_fall();
    wr_isc(4'b0010);
    wr_gicr(3'b001);
    bus_if.pin_in[0] = 1'b0;
    for (int j = 1; j <= N + 1; j++) begin
      exp_q.push_back('{"int0_fall", exp_outs((j == N + 1) ? 3'b001 : 3'b000,
                                              (j == N + 1) ? 3'b001 : 3'b000)});
      tick();
      got = exp_q.pop_front(); chk_cnt++;
      if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
      else pass_cnt++;
    end
    bus_if.irq_ack = 3'b001;
    exp_q.push_back('{"int0_ack", exp_outs(3'b000, 3'b000)});
    tick();
    bus_if.irq_ack = 3'b000;
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
    // Rising edge in falling mode must not flag.
    bus_if.pin_in[0] = 1'b1;
    repeat (N + 1) tick();
    exp_q.push_back('{"int0_rise_ignored", exp_outs(3'b000, 3'b000)});
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
  endtask

  task automatic test_int1_level();
    wr_isc(4'b0000);
    wr_gicr(3'b010);
    bus_if.pin_in[1] = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      exp_q.push_back('{"int1_level_low", exp_outs(3'b000, (j >= N) ? 3'b010 : 3'b000)});
      tick();
      got = exp_q.pop_front(); chk_cnt++;
      if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
      else pass_cnt++;
    end
    bus_if.pin_in[1] = 1'b1;
    for (int j = 1; j <= N + 1; j++) begin
      exp_q.push_back('{"int1_level_high", exp_outs(3'b000, (j >= N) ? 3'b000 : 3'b010)});
      tick();
      got = exp_q.pop_front(); chk_cnt++;
      if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
      else pass_cnt++;
    end
  endtask

  task automatic test_set_beats_clear();
    wr_isc2(1'b1);
    wr_gicr(3'b100);
    bus_if.pin_in[2] = 1'b0;
    repeat (N + 2) tick();
    bus_if.pin_in[2] = 1'b1;
    for (int j = 1; j <= N; j++) begin
      exp_q.push_back('{"int2_wait", exp_outs(3'b000, 3'b000)});
      tick();
      got = exp_q.pop_front(); chk_cnt++;
      if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
      else pass_cnt++;
    end
    bus_if.gifr_data = 3'b100; bus_if.gifr_we = 1'b1;
    exp_q.push_back('{"set_beats_clear", exp_outs(3'b100, 3'b100)});
    tick();
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
    exp_q.push_back('{"gifr_clear", exp_outs(3'b000, 3'b000)});
    tick();
    bus_if.gifr_we = 1'b0;
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
  endtask

  task automatic test_masked_flag();
    wr_gicr(3'b000);
    wr_isc(4'b0011);
    bus_if.pin_in[0] = 1'b0;
    repeat (N + 2) tick();
    bus_if.pin_in[0] = 1'b1;
    for (int j = 1; j <= N + 1; j++) begin
      exp_q.push_back('{"masked_flag", exp_outs((j == N + 1) ? 3'b001 : 3'b000, 3'b000)});
      tick();
      got = exp_q.pop_front(); chk_cnt++;
      if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
      else pass_cnt++;
    end
    wr_gicr(3'b001);
    exp_q.push_back('{"masked_enable", exp_outs(3'b001, 3'b001)});
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
  endtask

  task automatic test_isc_guard();
    wr_gifr(3'b001);
    bus_if.pin_in[0] = 1'b0;
    repeat (N + 2) tick();
    wr_isc(4'b0010);
    bus_if.pin_in[0] = 1'b1;
    repeat (N) tick();
    bus_if.isc_data = 4'b0011; bus_if.isc_we = 1'b1; m_isc = 4'b0011;
    exp_q.push_back('{"guard_mode_change", exp_outs(3'b000, 3'b000)});
    tick();
    bus_if.isc_we = 1'b0;
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
    exp_q.push_back('{"guard_after", exp_outs(3'b000, 3'b000)});
    tick();
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
    bus_if.pin_in[0] = 1'b0;
    repeat (N + 2) tick();
    bus_if.pin_in[0] = 1'b1;
    for (int j = 1; j <= N + 1; j++) begin
      exp_q.push_back('{"guard_real_rise", exp_outs((j == N + 1) ? 3'b001 : 3'b000,
                                                    (j == N + 1) ? 3'b001 : 3'b000)});
      tick();
      got = exp_q.pop_front(); chk_cnt++;
      if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
      else pass_cnt++;
    end
    // Entering level mode drops the pending INT0 flag.
    wr_isc(4'b0000);
    exp_q.push_back('{"level_entry_clear", exp_outs(3'b000, 3'b000)});
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
    // Any-change mode: an edge landing on a sense-mode write cycle is masked.
    wr_isc(4'b0001);
    bus_if.pin_in[0] = 1'b0;
    repeat (N) tick();
    bus_if.isc_data = 4'b0001; bus_if.isc_we = 1'b1;
    exp_q.push_back('{"guard_any_change", exp_outs(3'b000, 3'b000)});
    tick();
    bus_if.isc_we = 1'b0;
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
    exp_q.push_back('{"guard_prev_updates", exp_outs(3'b000, 3'b000)});
    tick();
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 6; j++) begin
      bus_if.pin_in[0] = ~bus_if.pin_in[0];
      tick();
    end
    repeat (N + 1) tick();
    exp_q.push_back('{"toggle_flag_held", exp_outs(3'b001, 3'b001)});
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
    bus_if.irq_ack = 3'b001;
    exp_q.push_back('{"toggle_ack", exp_outs(3'b000, 3'b000)});
    tick();
    bus_if.irq_ack = 3'b000;
    got = exp_q.pop_front(); chk_cnt++;
    if (obs !== got.outs) $display("FAIL %s: actual=%b required=%b", got.tag, obs, got.outs);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_int0_fall();
    test_int1_level();
    test_set_beats_clear();
    test_masked_flag();
    test_isc_guard();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
